// File: rtl/color_pkg.sv
// Shared definitions for the colour-detection path: pixel/frame classes,
// RESULT bit positions and RGB332 field positions.
package color_pkg;

   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_RED   = 2'd1,
      CLS_BLUE  = 2'd2,
      CLS_WHITE = 2'd3
   } cls_e;

   // RESULT bit indices; [2:0] are always zero
   localparam int RES_NONE = 5;
   localparam int RES_BLUE = 4;
   localparam int RES_RED  = 3;

   // RGB332 field positions
   localparam int PIX_R_HI = 7;
   localparam int PIX_R_LO = 5;
   localparam int PIX_G_HI = 4;
   localparam int PIX_G_LO = 2;
   localparam int PIX_B_HI = 1;
   localparam int PIX_B_LO = 0;

endpackage

// File: rtl/rgb332_pixel_class.sv
// Combinational RGB332 pixel classifier: red, blue, white (8'hFF) or none.
module rgb332_pixel_class
   import color_pkg::*;
#(
   parameter int RED_MIN   = 6,
   parameter int BLUE_MIN  = 2,
   parameter int CROSS_MAX = 2
) (
   input  logic [7:0] i_pixel,
   output cls_e       o_cls
);

   localparam logic [2:0] LP_RED_MIN  = 3'(RED_MIN);
   localparam logic [2:0] LP_CROSS    = 3'(CROSS_MAX);
   localparam logic [1:0] LP_BLUE_MIN = 2'(BLUE_MIN);
   // B is only two bits wide, so the red test uses the halved cross limit
   localparam logic [1:0] LP_B_CROSS  = 2'(CROSS_MAX >> 1);

   logic [2:0] w_r;
   logic [2:0] w_g;
   logic [1:0] w_b;

   assign w_r = i_pixel[PIX_R_HI:PIX_R_LO];
   assign w_g = i_pixel[PIX_G_HI:PIX_G_LO];
   assign w_b = i_pixel[PIX_B_HI:PIX_B_LO];

   // Map the pixel to a class; red and blue are mutually exclusive by threshold
   always_comb begin
      o_cls = CLS_NONE;
      if (i_pixel == 8'hFF)
         o_cls = CLS_WHITE;
      else if (w_r >= LP_RED_MIN && w_g <= LP_CROSS && w_b <= LP_B_CROSS)
         o_cls = CLS_RED;
      else if (w_b >= LP_BLUE_MIN && w_r <= LP_CROSS && w_g <= LP_CROSS)
         o_cls = CLS_BLUE;
   end

endmodule

// File: rtl/color_frame_voter.sv
// Per-frame colour voter: counts classified ROI pixels, decides a frame class
// at each VSYNC falling edge and majority-votes over VOTE_FRAMES frames.
module color_frame_voter
   import color_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int RED_MIN     = 6,
   parameter int BLUE_MIN    = 2,
   parameter int CROSS_MAX   = 2,
   parameter int MARGIN_BLUE = 2000,
   parameter int MARGIN_RED  = 3000,
   parameter int MIN_PIX     = 500,
   parameter int ROI_X0      = 0,
   parameter int ROI_X1      = 176,
   parameter int ROI_Y0      = 0,
   parameter int ROI_Y1      = 144,
   parameter int VOTE_FRAMES = 5,
   parameter int VOTE_MIN    = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [7:0]       PIXEL_IN,
   input  logic             PIXEL_VALID,
   input  logic [9:0]       VGA_PIXEL_X,
   input  logic [9:0]       VGA_PIXEL_Y,
   input  logic             VGA_VSYNC_NEG,
   output logic [5:0]       RESULT,
   output logic             RESULT_VALID,
   output logic [CNT_W-1:0] LAST_RED_CNT,
   output logic [CNT_W-1:0] LAST_BLUE_CNT
);

   localparam int VW  = $clog2(VOTE_FRAMES + 1);
   localparam int CW1 = CNT_W + 1;

   localparam logic [CNT_W-1:0] LP_CMAX = '1;
   localparam logic [CW1-1:0]   LP_MB   = CW1'(MARGIN_BLUE);
   localparam logic [CW1-1:0]   LP_MR   = CW1'(MARGIN_RED);
   localparam logic [CW1-1:0]   LP_MIN  = CW1'(MIN_PIX);
   localparam logic [10:0]      LP_X0   = 11'(ROI_X0);
   localparam logic [10:0]      LP_X1   = 11'(ROI_X1);
   localparam logic [10:0]      LP_Y0   = 11'(ROI_Y0);
   localparam logic [10:0]      LP_Y1   = 11'(ROI_Y1);
   localparam logic [VW-1:0]    LP_VF   = VW'(VOTE_FRAMES);
   localparam logic [VW-1:0]    LP_VMIN = VW'(VOTE_MIN);
   localparam logic [5:0]       LP_RES0 = 6'(1 << RES_NONE);

   cls_e             w_pix_cls;
   logic             w_count;
   logic             w_edge;
   logic             w_hit_red;
   logic             w_hit_blue;
   logic             w_hit_white;
   logic             w_close;
   cls_e             w_dec;
   logic [5:0]       w_result;
   logic [CW1-1:0]   w_red_x;
   logic [CW1-1:0]   w_blue_x;
   logic [CW1-1:0]   w_white_x;

   logic             r_vsync_prev;
   logic [CNT_W-1:0] r_red_cnt;
   logic [CNT_W-1:0] r_blue_cnt;
   logic [CNT_W-1:0] r_white_cnt;
   logic             r_s1_valid;
   logic [CNT_W-1:0] r_s1_red;
   logic [CNT_W-1:0] r_s1_blue;
   logic [CNT_W-1:0] r_s1_white;
   logic [VW-1:0]    r_vote_red;
   logic [VW-1:0]    r_vote_blue;
   logic [VW-1:0]    r_idx;

   rgb332_pixel_class #(
      .RED_MIN   (RED_MIN),
      .BLUE_MIN  (BLUE_MIN),
      .CROSS_MAX (CROSS_MAX)
   ) u_class (
      .i_pixel (PIXEL_IN),
      .o_cls   (w_pix_cls)
   );

   assign w_count = PIXEL_VALID &&
                    ({1'b0, VGA_PIXEL_X} >= LP_X0) && ({1'b0, VGA_PIXEL_X} < LP_X1) &&
                    ({1'b0, VGA_PIXEL_Y} >= LP_Y0) && ({1'b0, VGA_PIXEL_Y} < LP_Y1);
   assign w_edge      = r_vsync_prev && !VGA_VSYNC_NEG;
   assign w_hit_red   = w_count && (w_pix_cls == CLS_RED);
   assign w_hit_blue  = w_count && (w_pix_cls == CLS_BLUE);
   assign w_hit_white = w_count && (w_pix_cls == CLS_WHITE);

   // Saturating pixel counters; on the edge, snapshot and reload with the edge pixel
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_vsync_prev  <= 1'b0;
         r_red_cnt     <= '0;
         r_blue_cnt    <= '0;
         r_white_cnt   <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_red      <= '0;
         r_s1_blue     <= '0;
         r_s1_white    <= '0;
         LAST_RED_CNT  <= '0;
         LAST_BLUE_CNT <= '0;
      end else begin
         r_vsync_prev <= VGA_VSYNC_NEG;
         r_s1_valid   <= w_edge;
         if (w_edge) begin
            r_s1_red      <= r_red_cnt;
            r_s1_blue     <= r_blue_cnt;
            r_s1_white    <= r_white_cnt;
            LAST_RED_CNT  <= r_red_cnt;
            LAST_BLUE_CNT <= r_blue_cnt;
            r_red_cnt     <= CNT_W'(w_hit_red);
            r_blue_cnt    <= CNT_W'(w_hit_blue);
            r_white_cnt   <= CNT_W'(w_hit_white);
         end else begin
            if (w_hit_red && r_red_cnt != LP_CMAX)
               r_red_cnt <= r_red_cnt + 1'b1;
            if (w_hit_blue && r_blue_cnt != LP_CMAX)
               r_blue_cnt <= r_blue_cnt + 1'b1;
            if (w_hit_white && r_white_cnt != LP_CMAX)
               r_white_cnt <= r_white_cnt + 1'b1;
         end
      end
   end

   assign w_red_x   = {1'b0, r_s1_red};
   assign w_blue_x  = {1'b0, r_s1_blue};
   assign w_white_x = {1'b0, r_s1_white};

   // Frame decision from the snapshot; margins are added, never subtracted
   always_comb begin
      w_dec = CLS_NONE;
      if (w_blue_x >= w_red_x + LP_MB && w_blue_x >= LP_MIN)
         w_dec = CLS_BLUE;
      else if (w_red_x >= w_blue_x + LP_MR && w_red_x >= w_white_x + LP_MR &&
               w_red_x >= LP_MIN)
         w_dec = CLS_RED;
   end

   assign w_close = (r_idx == LP_VF);

   // Vote accumulation per decided frame; cleared when the window closes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_vote_red  <= '0;
         r_vote_blue <= '0;
         r_idx       <= '0;
      end else if (r_s1_valid) begin
         if (w_dec == CLS_RED)
            r_vote_red <= r_vote_red + 1'b1;
         if (w_dec == CLS_BLUE)
            r_vote_blue <= r_vote_blue + 1'b1;
         r_idx <= r_idx + 1'b1;
      end else if (w_close) begin
         r_vote_red  <= '0;
         r_vote_blue <= '0;
         r_idx       <= '0;
      end
   end

   // Window verdict; blue wins a tie
   always_comb begin
      w_result = '0;
      if (r_vote_blue >= LP_VMIN)
         w_result[RES_BLUE] = 1'b1;
      else if (r_vote_red >= LP_VMIN)
         w_result[RES_RED] = 1'b1;
      else
         w_result[RES_NONE] = 1'b1;
   end

   // Result register and one-cycle valid pulse
   always_ff @(posedge CLK) begin
      if (RESET) begin
         RESULT       <= LP_RES0;
         RESULT_VALID <= 1'b0;
      end else begin
         RESULT_VALID <= w_close;
         if (w_close)
            RESULT <= w_result;
      end
   end

endmodule

// File: tb/tb_color_frame_voter.sv
// Scoreboard bench: three voters (defaults, VOTE_FRAMES=1, CNT_W=8) share one
// pixel stream; a frame-level model predicts each window verdict and its cycle.
module tb_color_frame_voter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] PIXEL_IN;
   logic       PIXEL_VALID;
   logic [9:0] VGA_PIXEL_X;
   logic [9:0] VGA_PIXEL_Y;
   logic       VGA_VSYNC_NEG;

   logic [5:0]  res0, res1, res8;
   logic        rv0, rv1, rv8;
   logic [15:0] lr0, lb0, lr1, lb1;
   logic [7:0]  lr8, lb8;

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   color_frame_voter u_dut0 (
      .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
      .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
      .RESULT(res0), .RESULT_VALID(rv0), .LAST_RED_CNT(lr0), .LAST_BLUE_CNT(lb0)
   );

   color_frame_voter #(.VOTE_FRAMES(1), .VOTE_MIN(1)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
      .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
      .RESULT(res1), .RESULT_VALID(rv1), .LAST_RED_CNT(lr1), .LAST_BLUE_CNT(lb1)
   );

   color_frame_voter #(.CNT_W(8)) u_dut8 (
      .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
      .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
      .RESULT(res8), .RESULT_VALID(rv8), .LAST_RED_CNT(lr8), .LAST_BLUE_CNT(lb8)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [5:0] res;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t ex0, ex1;

   int vf[2]   = '{5, 1};
   int vmin[2] = '{3, 1};
   int vr[2]   = '{0, 0};
   int vb[2]   = '{0, 0};
   int vi[2]   = '{0, 0};

   // 0 = none, 1 = red, 2 = blue
   function automatic int frame_cls(input int r, input int b, input int w);
      if (b >= r + 2000 && b >= 500) return 2;
      if (r >= b + 3000 && r >= w + 3000 && r >= 500) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         vr[m] = 0;
         vb[m] = 0;
         vi[m] = 0;
      end
   endtask

   task automatic model_frame(input int r, input int b, input int w, input int e_cyc);
      int   c;
      exp_t e;
      c = frame_cls(r, b, w);
      for (int m = 0; m < 2; m++) begin
         if (c == 1) vr[m]++;
         if (c == 2) vb[m]++;
         vi[m]++;
         if (vi[m] == vf[m]) begin
            if (vb[m] >= vmin[m])      e.res = 6'b010000;
            else if (vr[m] >= vmin[m]) e.res = 6'b001000;
            else                       e.res = 6'b100000;
            e.cyc = e_cyc + 2;
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
            vr[m] = 0;
            vb[m] = 0;
            vi[m] = 0;
         end
      end
   endtask

   task automatic drive_pixels(input logic [7:0] p, input int n, input bit in_roi);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         PIXEL_VALID = 1'b1;
         PIXEL_IN    = p;
         VGA_PIXEL_X = in_roi ? 10'(i % 176) : 10'd200;
         VGA_PIXEL_Y = 10'((i / 176) % 144);
      end
   endtask

   // Pixels, then a one-cycle VSYNC high pulse whose fall is the frame edge
   task automatic send_frame(input int r, input int b, input int w, input int r_out);
      int e;
      drive_pixels(8'hE0, r, 1'b1);
      drive_pixels(8'h03, b, 1'b1);
      drive_pixels(8'hFF, w, 1'b1);
      drive_pixels(8'hE0, r_out, 1'b0);
      @(negedge CLK);
      PIXEL_VALID   = 1'b0;
      VGA_VSYNC_NEG = 1'b1;
      @(negedge CLK);
      VGA_VSYNC_NEG = 1'b0;
      e = cyc + 1;
      @(negedge CLK);
      chk("last_red0",  32'(lr0), 32'(r));
      chk("last_blue0", 32'(lb0), 32'(b));
      chk("last_red1",  32'(lr1), 32'(r));
      chk("last_blue1", 32'(lb1), 32'(b));
      chk("last_red8",  32'(lr8), 32'((r > 255) ? 255 : r));
      chk("last_blue8", 32'(lb8), 32'((b > 255) ? 255 : b));
      model_frame(r, b, w, e);
   endtask

   task automatic do_reset(input int n);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      repeat (n) @(negedge CLK);
      RESET = 1'b0;
      model_reset();
   endtask

   // Scoreboard: every RESULT_VALID must match the next predicted verdict and cycle
   always @(negedge CLK) begin
      if (rv0) begin
         if (q0.size() == 0) chk("unexpected_valid0", 32'(rv0), 32'd0);
         else begin
            ex0 = q0.pop_front();
            chk("result0", 32'(res0), 32'(ex0.res));
            chk("latency0", 32'(cyc), 32'(ex0.cyc));
         end
      end
      if (rv1) begin
         if (q1.size() == 0) chk("unexpected_valid1", 32'(rv1), 32'd0);
         else begin
            ex1 = q1.pop_front();
            chk("result1", 32'(res1), 32'(ex1.res));
            chk("latency1", 32'(cyc), 32'(ex1.cyc));
         end
      end
   end

   initial begin
      RESET         = 1'b1;
      PIXEL_IN      = 8'h00;
      PIXEL_VALID   = 1'b0;
      VGA_PIXEL_X   = '0;
      VGA_PIXEL_Y   = '0;
      VGA_VSYNC_NEG = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);

      // Reset state
      chk("rst_result0", 32'(res0), 32'h20);
      chk("rst_valid0",  32'(rv0),  32'd0);
      chk("rst_last_r0", 32'(lr0),  32'd0);
      chk("rst_last_b0", 32'(lb0),  32'd0);
      chk("rst_result1", 32'(res1), 32'h20);
      chk("rst_valid1",  32'(rv1),  32'd0);
      chk("rst_last_r8", 32'(lr8),  32'd0);

      // Blue majority, no-underflow, exact blue margin, white blocks red, exact red margin
      send_frame(2000, 10000, 0, 0);
      send_frame(1000, 500, 0, 0);
      send_frame(0, 2000, 0, 0);
      send_frame(3500, 0, 1000, 0);
      send_frame(3000, 0, 0, 0);

      // Five-frame window: red, red, blue, red, empty
      do_reset(2);
      send_frame(3500, 0, 0, 0);
      send_frame(3500, 0, 0, 0);
      send_frame(0, 3500, 0, 0);
      send_frame(3500, 0, 0, 0);
      send_frame(0, 0, 0, 0);

      // Saturation with CNT_W=8 and out-of-ROI pixels ignored
      do_reset(2);
      send_frame(300, 0, 0, 500);

      // Reset mid-window discards red votes
      do_reset(2);
      send_frame(3500, 0, 0, 0);
      send_frame(3500, 0, 0, 0);
      do_reset(1);
      for (int k = 0; k < 5; k++) send_frame(0, 3500, 0, 0);

      repeat (6) @(negedge CLK);
      chk("pending0", 32'(q0.size()), 32'd0);
      chk("pending1", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
